// File: rtl/switch_event_scheduler_pkg.sv
// Shared definitions for the switch event scheduler: FSM encoding, index width
// and a counter-width helper.
package switch_event_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLASH = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int IDX_W = 3;

    // Width of a counter that runs 0..limit-1 and is cleared on its terminal value.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/switch_event_scheduler_priority_pick.sv
// Combinational fixed-priority picker: lowest set request bit wins.
// Produces a one-hot grant, its binary index and an any-request flag.
module priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/switch_event_scheduler.sv
// Arbitrated release-event server: blinks the LED of one served switch at a
// time, then latches its toggled state, with an idle gap between services.
module switch_event_scheduler
    import switch_event_scheduler_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int TICKS_PER_HALF = 1250000,
    parameter int BLINK_COUNT    = 3,
    parameter int GAP_TICKS      = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_LED,
    output logic              o_Busy,
    output logic [IDX_W-1:0]  o_Active_Idx,
    output logic [NUM_SW-1:0] o_Pending
);

    localparam int TICK_W = cnt_width(TICKS_PER_HALF);
    localparam int HALF_W = cnt_width(2 * BLINK_COUNT);
    localparam int GAP_W  = cnt_width(GAP_TICKS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_HALF - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * BLINK_COUNT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    logic [NUM_SW-1:0] switch_q, switch_d;
    logic [NUM_SW-1:0] pend_q, pend_d;
    logic [NUM_SW-1:0] toggle_q, toggle_d;
    logic [NUM_SW-1:0] led_q, led_d;
    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  active_q, active_d;
    logic              phase_q, phase_d;
    logic              busy_q, busy_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [NUM_SW-1:0] release_evt;
    logic [NUM_SW-1:0] clr_mask;
    logic [NUM_SW-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    priority_pick #(
        .N     (NUM_SW),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (pend_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign release_evt = ~i_Switch & switch_q;

    always_comb begin
        switch_d = i_Switch;
        state_d  = state_q;
        active_d = active_q;
        phase_d  = phase_q;
        tick_d   = tick_q;
        half_d   = half_q;
        gap_d    = gap_q;
        toggle_d = toggle_q;
        clr_mask = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    active_d = pick_idx;
                    clr_mask = pick_grant;
                    phase_d  = 1'b1;
                    tick_d   = '0;
                    half_d   = '0;
                    gap_d    = '0;
                    state_d  = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    phase_d = ~phase_q;
                    if (half_q == HALF_LAST) begin
                        half_d  = '0;
                        gap_d   = '0;
                        state_d = ST_GAP;
                        for (int i = 0; i < NUM_SW; i++) begin
                            if (active_q == IDX_W'(i)) toggle_d[i] = ~toggle_q[i];
                        end
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A release on the grant edge re-queues the same index: set wins over clear.
        pend_d = (pend_q & ~clr_mask) | release_evt;

        busy_d = (state_d != ST_IDLE);
        for (int i = 0; i < NUM_SW; i++) begin
            led_d[i] = (state_d == ST_FLASH && active_d == IDX_W'(i)) ? phase_d : toggle_d[i];
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            switch_q <= '0;
            pend_q   <= '0;
            toggle_q <= '0;
            led_q    <= '0;
            state_q  <= ST_IDLE;
            active_q <= '0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            tick_q   <= '0;
            half_q   <= '0;
            gap_q    <= '0;
        end else begin
            switch_q <= switch_d;
            pend_q   <= pend_d;
            toggle_q <= toggle_d;
            led_q    <= led_d;
            state_q  <= state_d;
            active_q <= active_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            half_q   <= half_d;
            gap_q    <= gap_d;
        end
    end

    assign o_LED        = led_q;
    assign o_Busy       = busy_q;
    assign o_Active_Idx = active_q;
    assign o_Pending    = pend_q;

endmodule
